// File: rtl/drive_pkg.sv
// drive_pkg: shared definitions for the drive/memory block-transfer engine.
//   - dma_state_t : transfer state machine encoding
//   - DRIVE_AW, MEM_AW, DW : default address and data widths
//   - DIR_* : values of the transfer direction bit
package drive_pkg;

    localparam int DRIVE_AW = 24;
    localparam int MEM_AW   = 16;
    localparam int DW       = 16;

    localparam logic DIR_DRIVE_TO_MEM = 1'b0;
    localparam logic DIR_MEM_TO_DRIVE = 1'b1;

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        READ,
        WRITE,
        DONE
    } dma_state_t;

endpackage

// File: rtl/drive_dma.sv
// drive_dma: copies a block of words between main memory and the external
// drive over the shared tri-state data bus, two cycles per word while the bus
// grant is held.
//
// Ports:
//   clk, r          clock, synchronous active-high reset
//   start, dir      transfer request and direction (0 drive->mem, 1 mem->drive)
//   drive_base      first drive word address
//   mem_base        first memory word address
//   count           number of words (0 completes immediately)
//   abort           stop after the word currently in its WRITE cycle
//   busy, done      transfer in progress / one-cycle completion pulse
//   aborted         sticky: last transfer ended by abort
//   bus_req/bus_gnt bus arbitration handshake
//   bus             shared data bus, driven only during WRITE
//   drive_addr/we/oe, mem_addr/we/oe  drive and memory ports
module drive_dma
    import drive_pkg::*;
#(
    parameter int DRIVE_AW = drive_pkg::DRIVE_AW,
    parameter int MEM_AW   = drive_pkg::MEM_AW,
    parameter int DW       = drive_pkg::DW
) (
    input  logic                clk,
    input  logic                r,
    input  logic                start,
    input  logic                dir,
    input  logic [DRIVE_AW-1:0] drive_base,
    input  logic [MEM_AW-1:0]   mem_base,
    input  logic [15:0]         count,
    input  logic                abort,
    output logic                busy,
    output logic                done,
    output logic                aborted,
    output logic                bus_req,
    input  logic                bus_gnt,
    inout  wire  [DW-1:0]       bus,
    output logic [DRIVE_AW-1:0] drive_addr,
    output logic                drive_we,
    output logic                drive_oe,
    output logic [MEM_AW-1:0]   mem_addr,
    output logic                mem_we,
    output logic                mem_oe
);

    dma_state_t      state;
    logic            dir_q;
    logic [15:0]     remaining;
    logic            bus_en;
    logic [DW-1:0]   data_q;

    assign bus = bus_en ? data_q : {DW{1'bz}};

    // State, counters and all strobes are registered together. Each strobe is
    // loaded with the value belonging to the state being entered, so every
    // output is a clean function of the current state.
    always_ff @(posedge clk) begin
        if (r) begin
            state      <= IDLE;
            dir_q      <= DIR_DRIVE_TO_MEM;
            remaining  <= '0;
            busy       <= 1'b0;
            done       <= 1'b0;
            aborted    <= 1'b0;
            bus_req    <= 1'b0;
            bus_en     <= 1'b0;
            drive_we   <= 1'b0;
            drive_oe   <= 1'b0;
            mem_we     <= 1'b0;
            mem_oe     <= 1'b0;
            drive_addr <= '0;
            mem_addr   <= '0;
        end else begin
            done     <= 1'b0;
            bus_en   <= 1'b0;
            drive_we <= 1'b0;
            drive_oe <= 1'b0;
            mem_we   <= 1'b0;
            mem_oe   <= 1'b0;

            case (state)
                IDLE: begin
                    if (start) begin
                        dir_q      <= dir;
                        drive_addr <= drive_base;
                        mem_addr   <= mem_base;
                        remaining  <= count;
                        aborted    <= 1'b0;
                        busy       <= 1'b1;
                        if (count == 16'd0) begin
                            state <= DONE;
                            done  <= 1'b1;
                        end else begin
                            state   <= REQ;
                            bus_req <= 1'b1;
                        end
                    end
                end

                REQ: begin
                    if (bus_gnt) begin
                        state    <= READ;
                        drive_oe <= (dir_q == DIR_DRIVE_TO_MEM);
                        mem_oe   <= (dir_q == DIR_MEM_TO_DRIVE);
                    end
                end

                READ: begin
                    state    <= WRITE;
                    bus_en   <= 1'b1;
                    drive_we <= (dir_q == DIR_MEM_TO_DRIVE);
                    mem_we   <= (dir_q == DIR_DRIVE_TO_MEM);
                end

                WRITE: begin
                    drive_addr <= drive_addr + 1'b1;
                    mem_addr   <= mem_addr + 1'b1;
                    remaining  <= remaining - 1'b1;
                    // Grant loss is only looked at here, after a whole word.
                    if (remaining == 16'd1 || abort) begin
                        state   <= DONE;
                        done    <= 1'b1;
                        bus_req <= 1'b0;
                        if (abort) begin
                            aborted <= 1'b1;
                        end
                    end else if (!bus_gnt) begin
                        state <= REQ;
                    end else begin
                        state    <= READ;
                        drive_oe <= (dir_q == DIR_DRIVE_TO_MEM);
                        mem_oe   <= (dir_q == DIR_MEM_TO_DRIVE);
                    end
                end

                DONE: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end

                default: begin
                    state   <= IDLE;
                    busy    <= 1'b0;
                    bus_req <= 1'b0;
                end
            endcase
        end
    end

    // Data register carries no reset: it is only observed while bus_en is set,
    // which always follows a READ that loaded it.
    always_ff @(posedge clk) begin
        if (state == READ) begin
            data_q <= bus;
        end
    end

endmodule

// File: tb/tb_drive_dma.sv
// tb_drive_dma: table-driven bench for drive_dma. Small drive and memory
// models answer the bus on the _oe strobes; every WRITE-cycle capture and
// every READ-cycle address is logged and compared against values computed
// from each vector's bases and data pattern.
module tb_drive_dma;
    import drive_pkg::*;

    logic        clk = 1'b0;
    logic        r, start, dir, abort, bus_gnt;
    logic [23:0] drive_base;
    logic [15:0] mem_base, count;
    logic        busy, done, aborted, bus_req;
    logic        drive_we, drive_oe, mem_we, mem_oe;
    logic [23:0] drive_addr;
    logic [15:0] mem_addr;
    wire  [15:0] bus;

    always #5 clk = ~clk;

    drive_dma dut (
        .clk(clk), .r(r), .start(start), .dir(dir),
        .drive_base(drive_base), .mem_base(mem_base), .count(count),
        .abort(abort), .busy(busy), .done(done), .aborted(aborted),
        .bus_req(bus_req), .bus_gnt(bus_gnt), .bus(bus),
        .drive_addr(drive_addr), .drive_we(drive_we), .drive_oe(drive_oe),
        .mem_addr(mem_addr), .mem_we(mem_we), .mem_oe(mem_oe)
    );

    // Source models, indexed by the low address byte.
    logic [15:0] drv_arr [256];
    logic [15:0] mem_arr [256];
    assign bus = drive_oe ? drv_arr[drive_addr[7:0]] : 16'hzzzz;
    assign bus = mem_oe   ? mem_arr[mem_addr[7:0]]   : 16'hzzzz;

    // Transaction logs.
    logic [23:0] wl_a [256];
    logic [15:0] wl_d [256];
    logic        wl_p [256];
    logic [23:0] rl_a [256];
    int          wn = 0;
    int          rn = 0;

    always @(posedge clk) begin
        if (drive_we || mem_we) begin
            wl_a[wn[7:0]] <= drive_we ? drive_addr : {8'h00, mem_addr};
            wl_d[wn[7:0]] <= bus;
            wl_p[wn[7:0]] <= drive_we;
            wn <= wn + 1;
        end
        if (drive_oe || mem_oe) begin
            rl_a[rn[7:0]] <= drive_oe ? drive_addr : {8'h00, mem_addr};
            rn <= rn + 1;
        end
    end

    int checks = 0;
    int errors = 0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic check_idle(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " aborted"}, 32'(aborted), 32'd0);
        chk({tag, " bus_req"}, 32'(bus_req), 32'd0);
        chk({tag, " strobes"}, 32'({drive_we, drive_oe, mem_we, mem_oe}), 32'd0);
        chk({tag, " drive_addr"}, 32'(drive_addr), 32'd0);
        chk({tag, " mem_addr"}, 32'(mem_addr), 32'd0);
        chk({tag, " bus_en"}, 32'(dut.bus_en), 32'd0);
    endtask

    typedef struct {
        logic        dir;
        logic [23:0] dbase;
        logic [15:0] mbase;
        logic [15:0] cnt;
        int          stall_at;   // first cycle of a 5-cycle grant drop, 0 = none
        int          abort_at;   // WRITE cycle carrying abort, 0 = none
        int          exp_words;
        int          exp_done;   // cycle index of done after the start edge
        logic        exp_abt;
        logic [15:0] pat;
        logic [15:0] step;
    } vec_t;

    vec_t vecs [6];

    function automatic logic [15:0] word_val(input vec_t v, input int i);
        return v.pat + v.step * 16'(i);
    endfunction

    task automatic run_vec(input vec_t v, input string nm);
        int          w0, r0, c, done_c, first_rd, req_cnt;
        logic [23:0] da;
        logic [15:0] ma;
        logic [23:0] src_a, dst_a;
        for (int i = 0; i < 256; i++) begin
            drv_arr[i] = 16'hDEAD;
            mem_arr[i] = 16'hDEAD;
        end
        for (int i = 0; i < 16; i++) begin
            da = v.dbase + 24'(i);
            ma = v.mbase + 16'(i);
            if (v.dir == DIR_DRIVE_TO_MEM) drv_arr[da[7:0]] = word_val(v, i);
            else                           mem_arr[ma[7:0]] = word_val(v, i);
        end
        w0 = wn;
        r0 = rn;
        @(negedge clk);
        start = 1'b1; dir = v.dir; drive_base = v.dbase; mem_base = v.mbase;
        count = v.cnt; bus_gnt = 1'b1; abort = 1'b0;
        @(negedge clk);
        // Scramble the inputs to show they were latched with start.
        start = 1'b0; dir = ~v.dir; drive_base = 24'h5A5A5A; mem_base = 16'hA5A5; count = 16'h0007;
        c = 1; done_c = -1; first_rd = -1; req_cnt = 0;
        while (c <= 60) begin
            if (done && done_c < 0) done_c = c;
            if (bus_req) req_cnt++;
            if ((drive_oe || mem_oe) && first_rd < 0) first_rd = c;
            if (v.stall_at > 0 && c > v.stall_at && c <= v.stall_at + 5) begin
                chk({nm, " stall bus_req"}, 32'(bus_req), 32'd1);
                chk({nm, " stall strobes"}, 32'({drive_we, drive_oe, mem_we, mem_oe}), 32'd0);
                chk({nm, " stall bus_en"}, 32'(dut.bus_en), 32'd0);
            end
            if (done_c > 0 && c == done_c) begin
                chk({nm, " busy at done"}, 32'(busy), 32'd1);
                chk({nm, " bus_req at done"}, 32'(bus_req), 32'd0);
            end
            if (done_c > 0 && c == done_c + 1) begin
                chk({nm, " busy after done"}, 32'(busy), 32'd0);
                chk({nm, " done pulse width"}, 32'(done), 32'd0);
                break;
            end
            bus_gnt = !(v.stall_at > 0 && c >= v.stall_at && c < v.stall_at + 5);
            abort   = (v.abort_at > 0 && (c == v.abort_at || c == v.abort_at - 1));
            @(negedge clk);
            c++;
        end
        abort = 1'b0;
        bus_gnt = 1'b1;
        chk({nm, " done cycle"}, 32'(done_c), 32'(v.exp_done));
        chk({nm, " req cycles"}, 32'(req_cnt), 32'(v.exp_done - 1));
        chk({nm, " words written"}, 32'(wn - w0), 32'(v.exp_words));
        chk({nm, " words read"}, 32'(rn - r0), 32'(v.exp_words));
        chk({nm, " first read cycle"}, 32'(first_rd), (v.exp_words > 0) ? 32'd2 : 32'hFFFFFFFF);
        chk({nm, " aborted"}, 32'(aborted), 32'(v.exp_abt));
        for (int i = 0; i < v.exp_words && i < 16; i++) begin
            da = v.dbase + 24'(i);
            ma = v.mbase + 16'(i);
            src_a = (v.dir == DIR_DRIVE_TO_MEM) ? da : {8'h00, ma};
            dst_a = (v.dir == DIR_DRIVE_TO_MEM) ? {8'h00, ma} : da;
            chk({nm, $sformatf(" read addr %0d", i)}, 32'(rl_a[(r0 + i) % 256]), 32'(src_a));
            chk({nm, $sformatf(" write addr %0d", i)}, 32'(wl_a[(w0 + i) % 256]), 32'(dst_a));
            chk({nm, $sformatf(" write data %0d", i)}, 32'(wl_d[(w0 + i) % 256]), 32'(word_val(v, i)));
            chk({nm, $sformatf(" write port %0d", i)}, 32'(wl_p[(w0 + i) % 256]), 32'(v.dir));
        end
    endtask

    initial begin
        int w0, c;
        logic rst_ok;
        vecs[0] = '{1'b0, 24'h000100, 16'h2000, 16'd4, 0, 0, 4, 10, 1'b0, 16'hA000, 16'h0001};
        vecs[1] = '{1'b1, 24'h000000, 16'h0010, 16'd3, 0, 0, 3,  8, 1'b0, 16'h1111, 16'h1111};
        vecs[2] = '{1'b0, 24'hFFFFFE, 16'hFFFF, 16'd3, 0, 0, 3,  8, 1'b0, 16'h5000, 16'h0001};
        vecs[3] = '{1'b0, 24'h000040, 16'h0300, 16'd4, 5, 0, 4, 15, 1'b0, 16'hB000, 16'h0001};
        vecs[4] = '{1'b1, 24'h000080, 16'h0400, 16'd8, 0, 5, 2,  6, 1'b1, 16'hC000, 16'h0001};
        vecs[5] = '{1'b0, 24'h000020, 16'h0500, 16'd0, 0, 0, 0,  1, 1'b0, 16'h0000, 16'h0000};

        r = 1'b1; start = 1'b0; dir = 1'b0; abort = 1'b0; bus_gnt = 1'b1;
        drive_base = '0; mem_base = '0; count = '0;
        for (int i = 0; i < 256; i++) begin
            drv_arr[i] = 16'hDEAD;
            mem_arr[i] = 16'hDEAD;
        end
        repeat (3) @(negedge clk);
        check_idle("reset");
        r = 1'b0;

        for (int i = 0; i < 6; i++) begin
            run_vec(vecs[i], $sformatf("vec%0d", i));
        end

        // Leave aborted set, then reset in the middle of word 3's READ.
        run_vec(vecs[4], "abort again");
        for (int i = 0; i < 256; i++) begin
            drv_arr[i] = 16'h7000 + 16'(i);
            mem_arr[i] = 16'hDEAD;
        end
        w0 = wn;
        @(negedge clk);
        start = 1'b1; dir = DIR_DRIVE_TO_MEM; drive_base = 24'h000010;
        mem_base = 16'h0600; count = 16'd4; bus_gnt = 1'b1;
        @(negedge clk);
        start = 1'b0;
        c = 1;
        while (c < 6) begin
            @(negedge clk);
            c++;
        end
        chk("midop read strobe", 32'(drive_oe), 32'd1);
        r = 1'b1;
        @(negedge clk);
        check_idle("midop reset");
        rst_ok = 1'b1;
        @(negedge clk);
        r = 1'b0;
        chk("midop strobes held off", 32'({drive_we, drive_oe, mem_we, mem_oe}), 32'd0);
        chk("midop words written", 32'(wn - w0), 32'd2);
        if (rst_ok) run_vec(vecs[0], "after reset");

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
